// File: rtl/peripheral_spram_banked_rdpipe.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_spram_banked_rdpipe
//  Brief    : Single-port byte-writable RAM with self-clearing init and a
//             1- or 2-stage pipelined read path.
//  Revision : 1.0 - initial release
// ============================================================================
module peripheral_spram_banked_rdpipe #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MEM_SIZE = 1024,
  parameter int RD_LAT   = 1
) (
  input  logic              ram_clk,
  input  logic              ram_rst,
  input  logic              ram_req,
  output logic              ram_gnt,
  input  logic              ram_we,
  input  logic [AW-1:0]     ram_addr,
  input  logic [DW/8-1:0]   ram_be,
  input  logic [DW-1:0]     ram_din,
  output logic [DW-1:0]     ram_dout,
  output logic              ram_rvalid,
  output logic              init_done
);

  localparam int              c_NB      = DW / 8;
  localparam int              c_DEPTH   = MEM_SIZE / c_NB;
  localparam int              c_IW      = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
  localparam logic [c_IW-1:0] c_LAST    = c_IW'(c_DEPTH - 1);
  localparam logic [AW:0]     c_DEPTH_W = (AW + 1)'(c_DEPTH);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_IW-1:0] r_init_cnt;
  logic [c_IW-1:0] w_init_cnt_nxt;
  logic            w_init_we;
  logic            w_gnt;
  logic            w_done;

  logic [DW-1:0]   r_mem [c_DEPTH];
  logic [c_IW-1:0] w_idx;
  logic            w_in_range;
  logic            w_acc;
  logic            w_rd_acc;
  logic            w_wr_acc;
  logic [DW-1:0]   w_rd_data;

  logic [DW-1:0]   r_dout;
  logic            r_rvalid;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_init_we      = 1'b0;
    w_gnt          = 1'b0;
    w_done         = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = 1'b1;
        if (r_init_cnt == c_LAST) begin
          w_state_nxt = ST_READY;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 1'b1;
        end
      end
      ST_READY: begin
        w_gnt  = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign ram_gnt   = w_gnt;
  assign init_done = w_done;

  // ---------------------------------------------------------------- access decode
  // Upper address bits only matter for the range test; the array is indexed
  // with the low bits, which are always sufficient for in-range addresses.
  assign w_idx      = ram_addr[c_IW-1:0];
  assign w_in_range = ({1'b0, ram_addr} < c_DEPTH_W);
  assign w_acc      = ram_req && w_gnt;
  assign w_rd_acc   = w_acc && !ram_we;
  assign w_wr_acc   = w_acc && ram_we && w_in_range;
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : '0;

  // ---------------------------------------------------------------- storage
  always_ff @(posedge ram_clk) begin
    if (!ram_rst) begin
      if (w_init_we) begin
        r_mem[r_init_cnt] <= '0;
      end else if (w_wr_acc) begin
        for (int b = 0; b < c_NB; b++) begin
          if (ram_be[b]) begin
            r_mem[w_idx][8*b +: 8] <= ram_din[8*b +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- read pipe
  // Output data only loads on a valid beat so it holds between pulses.
  if (RD_LAT >= 2) begin : g_lat2
    logic          r_s1_vld;
    logic [DW-1:0] r_s1_data;

    always_ff @(posedge ram_clk) begin
      if (ram_rst) begin
        r_s1_vld  <= 1'b0;
        r_s1_data <= '0;
        r_rvalid  <= 1'b0;
        r_dout    <= '0;
      end else begin
        r_s1_vld <= w_rd_acc;
        if (w_rd_acc) begin
          r_s1_data <= w_rd_data;
        end
        r_rvalid <= r_s1_vld;
        if (r_s1_vld) begin
          r_dout <= r_s1_data;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge ram_clk) begin
      if (ram_rst) begin
        r_rvalid <= 1'b0;
        r_dout   <= '0;
      end else begin
        r_rvalid <= w_rd_acc;
        if (w_rd_acc) begin
          r_dout <= w_rd_data;
        end
      end
    end
  end

  assign ram_dout   = r_dout;
  assign ram_rvalid = r_rvalid;

endmodule
`default_nettype wire
